// File: rtl/dp_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : dp_multicycle
// Summary  : Multi-cycle register/RAM datapath with ALU, stack, branch unit
//            and sticky halt; one instruction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module dp_multicycle #(
    parameter  int DATA_W     = 32,
    parameter  int NREGS      = 8,
    parameter  int ADDR_W     = 10,
    parameter  int STACK_BASE = 10,
    parameter  int STACK_MIN  = 0,
    localparam int REG_AW     = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        alucode,
    input  logic              flag,
    input  logic              flag1,
    input  logic [REG_AW-1:0] op1,
    input  logic [20:0]       op2,
    input  logic              imControl,
    input  logic [4:0]        pcControl,
    input  logic [1:0]        stackSelect,
    input  logic              writecode,
    input  logic [DATA_W-1:0] memresult,
    output logic [ADDR_W-1:0] memaddr,
    output logic              writemem,
    output logic [DATA_W-1:0] writememdata,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              halted,
    output logic              err_div0,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam logic [3:0] c_IDLE = 4'd0;
    localparam logic [3:0] c_RD1A = 4'd1;
    localparam logic [3:0] c_RD1D = 4'd2;
    localparam logic [3:0] c_RD2A = 4'd3;
    localparam logic [3:0] c_RD2D = 4'd4;
    localparam logic [3:0] c_POPA = 4'd5;
    localparam logic [3:0] c_POPD = 4'd6;
    localparam logic [3:0] c_EXEC = 4'd7;
    localparam logic [3:0] c_WB   = 4'd8;

    localparam logic [ADDR_W-1:0] c_SP_BASE = ADDR_W'(STACK_BASE);
    localparam logic [ADDR_W-1:0] c_SP_MIN  = ADDR_W'(STACK_MIN);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;

    logic [4:0]        r_alucode;
    logic              r_flag;
    logic              r_flag1;
    logic [REG_AW-1:0] r_op1;
    logic [20:0]       r_op2;
    logic              r_imm;
    logic [4:0]        r_pcctl;
    logic [1:0]        r_stacksel;
    logic              r_wrcode;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_mnum1;
    logic [DATA_W-1:0] r_mnum2;
    logic [DATA_W-1:0] r_popdata;
    logic [ADDR_W-1:0] r_sp;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_result;
    logic [ADDR_W-1:0] r_memaddr;
    logic              r_writemem;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic              r_halted;
    logic              r_div0;
    logic              r_ovf;
    logic              r_unf;

    logic              w_accept;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rs3;
    logic [REG_AW-1:0] w_rs2_in;
    logic [DATA_W-1:0] w_num1;
    logic [DATA_W-1:0] w_num2;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_alu;
    logic              w_div0;
    logic              w_stack_en;
    logic              w_ovf;
    logic              w_unf;
    logic              w_pop_ok;
    logic              w_do_push;
    logic              w_do_dest;
    logic              w_mem_wr;
    logic              w_reg_wr;
    logic [DATA_W-1:0] w_towrite;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_taken;
    logic              w_halt;
    logic [DATA_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_memaddr_nxt;

    assign instr_ready  = (r_state == c_IDLE) && !r_halted;
    assign w_accept     = instr_ready && instr_valid;
    assign memaddr      = r_memaddr;
    assign writemem     = r_writemem;
    assign writememdata = r_wdata;
    assign PC           = r_pc;
    assign result       = r_result;
    assign done         = r_done;
    assign halted       = r_halted;
    assign err_div0     = r_div0;
    assign err_ovf      = r_ovf;
    assign err_unf      = r_unf;

    assign w_rs2    = REG_AW'(r_op2[20:18]);
    assign w_rs3    = REG_AW'(r_op2[17:15]);
    assign w_rs2_in = REG_AW'(op2[20:18]);

    // Register-sourced operands are stable for the whole instruction,
    // so they are read directly instead of being captured.
    assign w_imm  = {{(DATA_W-21){r_op2[20]}}, r_op2};
    assign w_num1 = r_flag ? r_mnum1 : r_regs[r_op1];
    assign w_num2 = r_imm ? w_imm : (r_flag1 ? r_mnum2 : r_regs[w_rs2]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (flag)                     w_state_nxt = c_RD1A;
                    else if (!imControl && flag1) w_state_nxt = c_RD2A;
                    else if (stackSelect == 2'd2) w_state_nxt = c_POPA;
                    else                          w_state_nxt = c_EXEC;
                end
            end
            c_RD1A: w_state_nxt = c_RD1D;
            c_RD1D: begin
                if (!r_imm && r_flag1)        w_state_nxt = c_RD2A;
                else if (r_stacksel == 2'd2)  w_state_nxt = c_POPA;
                else                          w_state_nxt = c_EXEC;
            end
            c_RD2A: w_state_nxt = c_RD2D;
            c_RD2D: w_state_nxt = (r_stacksel == 2'd2) ? c_POPA : c_EXEC;
            c_POPA: w_state_nxt = c_POPD;
            c_POPD: w_state_nxt = c_EXEC;
            c_EXEC: w_state_nxt = c_WB;
            c_WB:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_alu  = '1;
        w_div0 = 1'b0;
        case (r_alucode)
            5'd0:  w_alu = w_num1;
            5'd1:  w_alu = w_num1 + w_num2;
            5'd2:  w_alu = w_num1 - w_num2;
            5'd3:  w_alu = w_num1 * w_num2;
            5'd4: begin
                if (w_num2 == '0) w_div0 = 1'b1;
                else              w_alu  = w_num1 / w_num2;
            end
            5'd5: begin
                if (w_num2 == '0) w_div0 = 1'b1;
                else              w_alu  = w_num1 % w_num2;
            end
            5'd6:  w_alu = w_num1 | w_num2;
            5'd7:  w_alu = w_num1 & w_num2;
            5'd8:  w_alu = w_num1 ^ w_num2;
            5'd9:  w_alu = ~w_num1;
            5'd10: w_alu = w_num1 >> 1;
            5'd11: w_alu = w_num1 << 1;
            default: w_alu = '1;
        endcase
    end

    // Stack and destination writes only happen on sequential-flow instructions.
    always_comb begin
        w_stack_en = (r_pcctl == 5'd0);
        w_unf      = w_stack_en && (r_stacksel == 2'd2) && (r_sp == c_SP_BASE);
        w_ovf      = w_stack_en && (r_stacksel == 2'd1) && (r_sp == c_SP_MIN);
        w_pop_ok   = w_stack_en && (r_stacksel == 2'd2) && !w_unf;
        w_do_push  = w_stack_en && (r_stacksel == 2'd1) && !w_ovf;
        w_do_dest  = w_stack_en && (r_stacksel != 2'd1) && !w_unf;
        w_towrite  = w_pop_ok ? r_popdata : (r_wrcode ? w_num2 : w_alu);
        w_mem_wr   = w_do_push || (w_do_dest && r_flag);
        w_reg_wr   = w_do_dest && !r_flag;
        w_wr_addr  = w_do_push ? r_sp : r_regs[r_op1][ADDR_W-1:0];
        w_wr_data  = w_do_push ? w_num1 : w_towrite;
    end

    always_comb begin
        w_taken  = 1'b0;
        w_halt   = 1'b0;
        w_pc_nxt = r_pc + DATA_W'(1);
        case (r_pcctl)
            5'd0: w_taken = 1'b0;
            5'd1: w_taken = (w_num1 == w_num2);
            5'd2: w_taken = (w_num1 <  w_num2);
            5'd3: w_taken = (w_num1 >  w_num2);
            5'd4: w_taken = (w_num1 != w_num2);
            5'd5: w_taken = (w_num1 <= w_num2);
            5'd6: w_taken = (w_num1 >= w_num2);
            5'd7: w_taken = (w_num1 != '0);
            5'd8: w_taken = (w_num1 == '0);
            5'd9: w_pc_nxt = r_pc + r_regs[r_op1];
            default: begin
                w_pc_nxt = r_pc;
                w_halt   = 1'b1;
            end
        endcase
        if (w_taken) w_pc_nxt = r_pc + r_regs[w_rs3];
    end

    // The address register is loaded on entry to each access state so the
    // RAM sees it for the whole state.
    always_comb begin
        w_memaddr_nxt = r_memaddr;
        case (w_state_nxt)
            c_RD1A: w_memaddr_nxt = r_regs[op1][ADDR_W-1:0];
            c_RD2A: w_memaddr_nxt = (r_state == c_IDLE) ? r_regs[w_rs2_in][ADDR_W-1:0]
                                                        : r_regs[w_rs2][ADDR_W-1:0];
            c_POPA: w_memaddr_nxt = r_sp + ADDR_W'(1);
            c_WB:   if (w_mem_wr) w_memaddr_nxt = w_wr_addr;
            default: w_memaddr_nxt = r_memaddr;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_alucode  <= '0;
            r_flag     <= 1'b0;
            r_flag1    <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_imm      <= 1'b0;
            r_pcctl    <= '0;
            r_stacksel <= '0;
            r_wrcode   <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_mnum1    <= '0;
            r_mnum2    <= '0;
            r_popdata  <= '0;
            r_sp       <= c_SP_BASE;
            r_pc       <= '0;
            r_result   <= '0;
            r_memaddr  <= '0;
            r_writemem <= 1'b0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_halted   <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_memaddr  <= w_memaddr_nxt;
            r_writemem <= 1'b0;
            r_done     <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            if (w_accept) begin
                r_alucode  <= alucode;
                r_flag     <= flag;
                r_flag1    <= flag1;
                r_op1      <= op1;
                r_op2      <= op2;
                r_imm      <= imControl;
                r_pcctl    <= pcControl;
                r_stacksel <= stackSelect;
                r_wrcode   <= writecode;
            end
            case (r_state)
                c_RD1D: r_mnum1   <= memresult;
                c_RD2D: r_mnum2   <= memresult;
                c_POPD: r_popdata <= memresult;
                c_EXEC: begin
                    // Architectural updates commit here so that WB presents
                    // done, the error pulses and the RAM write together.
                    r_result   <= w_alu;
                    r_done     <= 1'b1;
                    r_div0     <= w_div0;
                    r_ovf      <= w_ovf;
                    r_unf      <= w_unf;
                    r_writemem <= w_mem_wr;
                    if (w_mem_wr) r_wdata <= w_wr_data;
                    if (w_reg_wr) r_regs[r_op1] <= w_towrite;
                    if (w_do_push)     r_sp <= r_sp - ADDR_W'(1);
                    else if (w_pop_ok) r_sp <= r_sp + ADDR_W'(1);
                    r_pc <= w_pc_nxt;
                    if (w_halt) r_halted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dp_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_multicycle
// Summary  : Randomised scoreboard bench for dp_multicycle with a sequential
//            instruction-level reference model and an external RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_multicycle;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 10;
    localparam int SB = 10;
    localparam int SM = 0;

    logic          clock = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [4:0]    alucode;
    logic          flag;
    logic          flag1;
    logic [2:0]    op1;
    logic [20:0]   op2;
    logic          imControl;
    logic [4:0]    pcControl;
    logic [1:0]    stackSelect;
    logic          writecode;
    logic [DW-1:0] memresult;
    logic [AW-1:0] memaddr;
    logic          writemem;
    logic [DW-1:0] writememdata;
    logic [DW-1:0] PC;
    logic [DW-1:0] result;
    logic          done;
    logic          halted;
    logic          err_div0;
    logic          err_ovf;
    logic          err_unf;

    always #5 clock = ~clock;

    dp_multicycle #(
        .DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .STACK_BASE(SB), .STACK_MIN(SM)
    ) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .alucode(alucode), .flag(flag), .flag1(flag1), .op1(op1), .op2(op2),
        .imControl(imControl), .pcControl(pcControl), .stackSelect(stackSelect),
        .writecode(writecode), .memresult(memresult), .memaddr(memaddr),
        .writemem(writemem), .writememdata(writememdata), .PC(PC),
        .result(result), .done(done), .halted(halted),
        .err_div0(err_div0), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    function automatic logic [DW-1:0] ram_seed(input int a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    // External RAM: one-cycle read latency, written on writemem.
    logic [DW-1:0] ram [1<<AW];
    logic          init_req = 1'b0;
    logic          poke_en  = 1'b0;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;
    always @(posedge clock) begin
        memresult <= ram[memaddr];
        if (init_req) for (int i = 0; i < (1<<AW); i++) ram[i] <= ram_seed(i);
        else if (poke_en) ram[poke_addr] <= poke_data;
        else if (writemem) ram[memaddr] <= writememdata;
    end

    // Reference model state
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_ram [1<<AW];
    int            m_sp;
    logic [DW-1:0] m_pc;
    bit            m_halted;

    typedef struct {
        logic [DW-1:0] res;
        logic [DW-1:0] pc;
        logic [2:0]    err;
        bit            halted;
        int            lat;
        int            nwr;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard on each retirement.
    int  cyc = 0;
    int  acc_cyc = 0;
    int  nwr_seen = 0;
    bit  chk_ready = 0;
    bit  exp_ready = 0;
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (reset) begin
            chk_ready = 0;
            nwr_seen  = 0;
        end else begin
            if (chk_ready) begin
                check("ready_after_done", {63'd0, instr_ready}, {63'd0, exp_ready});
                chk_ready = 0;
            end
            if (writemem) nwr_seen++;
            if (instr_valid && instr_ready) begin
                acc_cyc  = cyc;
                nwr_seen = 0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("result",  {32'd0, result}, {32'd0, e.res});
                    check("pc",      {32'd0, PC}, {32'd0, e.pc});
                    check("errors",  {61'd0, err_div0, err_ovf, err_unf}, {61'd0, e.err});
                    check("halted",  {63'd0, halted}, {63'd0, e.halted});
                    check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                    check("ram_writes", 64'(nwr_seen), 64'(e.nwr));
                    chk_ready = 1;
                    exp_ready = !e.halted;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_sp = SB;
        m_pc = '0;
        m_halted = 0;
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        q.delete();
        model_reset();
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        @(posedge clock); #1;
        poke_en = 1'b1; poke_addr = AW'(a); poke_data = d;
        m_ram[a] = d;
        @(posedge clock); #1;
        poke_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_timeout", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Issues one instruction, predicting its effect from the instruction rules.
    task automatic issue(input logic [4:0] alu, input bit fl, input bit fl1, input logic [2:0] o1,
                         input logic [20:0] o2, input bit im, input logic [4:0] pcc,
                         input logic [1:0] ss, input bit wc);
        exp_t e;
        logic [DW-1:0] n1, n2, res, tw, pop;
        int rs2, rs3, n;
        bit taken;
        @(posedge clock); #1;
        n = 0;
        while (!instr_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 64'd0, 64'd1);
            return;
        end
        rs2 = int'(o2[20:18]);
        rs3 = int'(o2[17:15]);
        e.lat = 2; e.nwr = 0; e.err = 3'b000; pop = '0; taken = 0;
        if (fl) begin
            n1 = m_ram[m_regs[o1][AW-1:0]];
            e.lat += 2;
        end else n1 = m_regs[o1];
        if (im) n2 = {{(DW-21){o2[20]}}, o2};
        else if (fl1) begin
            n2 = m_ram[m_regs[rs2][AW-1:0]];
            e.lat += 2;
        end else n2 = m_regs[rs2];
        if (ss == 2'd2) begin
            pop = m_ram[(m_sp + 1) % (1<<AW)];
            e.lat += 2;
        end
        case (alu)
            0: res = n1;
            1: res = n1 + n2;
            2: res = n1 - n2;
            3: res = n1 * n2;
            4: begin res = (n2 == 0) ? '1 : n1 / n2; e.err[2] = (n2 == 0); end
            5: begin res = (n2 == 0) ? '1 : n1 % n2; e.err[2] = (n2 == 0); end
            6: res = n1 | n2;
            7: res = n1 & n2;
            8: res = n1 ^ n2;
            9: res = ~n1;
            10: res = n1 >> 1;
            11: res = n1 << 1;
            default: res = '1;
        endcase
        tw = wc ? n2 : res;
        if (pcc == 0) begin
            if (ss == 2'd1) begin
                if (m_sp == SM) e.err[1] = 1;
                else begin
                    m_ram[m_sp] = n1;
                    m_sp--;
                    e.nwr = 1;
                end
            end else if (ss == 2'd2 && m_sp == SB) begin
                e.err[0] = 1;
            end else begin
                if (ss == 2'd2) begin
                    tw = pop;
                    m_sp++;
                end
                if (fl) begin
                    m_ram[m_regs[o1][AW-1:0]] = tw;
                    e.nwr = 1;
                end else m_regs[o1] = tw;
            end
        end
        case (pcc)
            0: ;
            1: taken = (n1 == n2);
            2: taken = (n1 <  n2);
            3: taken = (n1 >  n2);
            4: taken = (n1 != n2);
            5: taken = (n1 <= n2);
            6: taken = (n1 >= n2);
            7: taken = (n1 != 0);
            8: taken = (n1 == 0);
            default: ;
        endcase
        if (pcc == 9)      m_pc = m_pc + m_regs[o1];
        else if (pcc >= 10) m_halted = 1;
        else if (taken)    m_pc = m_pc + m_regs[rs3];
        else               m_pc = m_pc + 1;
        e.res = res; e.pc = m_pc; e.halted = m_halted;
        q.push_back(e);
        alucode = alu; flag = fl; flag1 = fl1; op1 = o1; op2 = o2;
        imControl = im; pcControl = pcc; stackSelect = ss; writecode = wc;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] r, input logic [20:0] imm);
        issue(5'd0, 0, 0, r, imm, 1, 5'd0, 2'd0, 1);
    endtask

    task automatic check_halt_hold();
        for (int i = 0; i < 4; i++) begin
            check("halt_ready_low", {63'd0, instr_ready}, 64'd0);
            check("halt_sticky", {63'd0, halted}, 64'd1);
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int bad;
        reset = 1'b1; instr_valid = 1'b0; alucode = '0; flag = 0; flag1 = 0;
        op1 = '0; op2 = '0; imControl = 0; pcControl = '0; stackSelect = '0; writecode = 0;
        poke_addr = '0; poke_data = '0;
        for (int i = 0; i < (1<<AW); i++) m_ram[i] = ram_seed(i);
        @(posedge clock); #1 init_req = 1'b1;
        @(posedge clock); #1 init_req = 1'b0;
        apply_reset();

        check("rst_pc", {32'd0, PC}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_memaddr", 64'(memaddr), 64'd0);
        check("rst_outs", {58'd0, writemem, done, halted, err_div0, err_ovf, err_unf}, 64'd0);
        check("rst_ready", {63'd0, instr_ready}, 64'd1);

        // Register-only subtract
        load(3'd1, 21'd7);
        load(3'd2, 21'd5);
        issue(5'd2, 0, 0, 3'd1, {3'd2, 18'd0}, 0, 5'd0, 2'd0, 0);
        drain();
        check("sub_const", {32'd0, result}, 64'd2);

        // Sign-extended immediate of -1
        load(3'd1, 21'd3);
        issue(5'd1, 0, 0, 3'd1, 21'h1FFFFF, 1, 5'd0, 2'd0, 0);
        drain();
        check("imm_neg1", {32'd0, result}, 64'd2);

        // Memory operand shifted and written back in place
        poke(20, 32'd9);
        load(3'd1, 21'd20);
        issue(5'd11, 1, 0, 3'd1, 21'd0, 0, 5'd0, 2'd0, 0);
        drain();
        check("mem_shl", {32'd0, ram[20]}, 64'd18);

        // Stack overflow and underflow
        apply_reset();
        for (int i = 0; i < 11; i++) issue(5'd0, 0, 0, 3'(i), 21'd0, 0, 5'd0, 2'd1, 0);
        drain();
        apply_reset();
        issue(5'd0, 0, 0, 3'd1, 21'd0, 0, 5'd0, 2'd2, 0);
        drain();

        // Divide by zero, then a taken branch
        apply_reset();
        load(3'd1, 21'd40);
        issue(5'd4, 0, 0, 3'd1, {3'd2, 18'd0}, 0, 5'd0, 2'd0, 0);
        drain();
        check("div0_result", {32'd0, result}, {32'd0, 32'hFFFF_FFFF});
        apply_reset();
        load(3'd3, 21'd5);
        load(3'd1, 21'd6);
        load(3'd2, 21'd6);
        load(3'd4, 21'd0);
        issue(5'd0, 0, 0, 3'd1, {3'd2, 3'd3, 15'd0}, 0, 5'd1, 2'd0, 0);
        drain();
        check("branch_pc", {32'd0, PC}, 64'd9);

        // Reset in the middle of a memory read aborts the instruction
        load(3'd1, 21'd30);
        drain();
        @(posedge clock); #1;
        alucode = 5'd1; flag = 1; flag1 = 0; op1 = 3'd1; op2 = 21'd0; imControl = 0;
        pcControl = 5'd0; stackSelect = 2'd0; writecode = 0; instr_valid = 1'b1;
        @(posedge clock); #1 instr_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        check("abort_wm_rd1d", {63'd0, writemem}, 64'd0);
        @(posedge clock); #1;
        check("abort_pc", {32'd0, PC}, 64'd0);
        check("abort_wm", {63'd0, writemem}, 64'd0);
        check("abort_idle", {63'd0, instr_ready}, 64'd1);
        reset = 1'b0;
        q.delete();
        model_reset();
        check("abort_ram", {32'd0, ram[30]}, {32'd0, m_ram[30]});

        // Halt is sticky until reset
        issue(5'd0, 0, 0, 3'd0, 21'd0, 0, 5'd10, 2'd0, 0);
        drain();
        check_halt_hold();
        apply_reset();

        // Randomised instruction stream
        for (int k = 0; k < 400; k++) begin
            int r;
            logic [4:0] pcc;
            logic [20:0] o2;
            r = $urandom_range(0, 19);
            if (r < 10) pcc = 5'd0;
            else if (r < 19) pcc = 5'(r - 9);
            else pcc = 5'($urandom_range(10, 31));
            o2 = ($urandom_range(0, 3) == 0) ? 21'($urandom) : {6'($urandom), 12'd0, 3'($urandom_range(0, 3))};
            if ($urandom_range(0, 2) == 0)
                load(3'($urandom), 21'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 40)));
            else
                issue(5'($urandom_range(0, 13)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      3'($urandom), o2, $urandom_range(0, 3) == 0, pcc,
                      2'($urandom), 1'($urandom_range(0, 4) == 0));
            if (m_halted) begin
                drain();
                check_halt_hold();
                apply_reset();
            end
        end
        drain();

        bad = 0;
        for (int i = 0; i < (1<<AW); i++) if (ram[i] !== m_ram[i]) bad++;
        check("ram_contents", 64'(bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
